pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined WIDTH-bit add/subtract unit; successor to the single-bit combinational adder cell.
//  Splits the carry chain into STAGES slices of CHUNK bits, one slice per clock, with valid/ready flow control.
//  Sits between operand sources (register file / ALU front end) and any result consumer that may back-pressure.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//  STAGES   4  pipeline depth = number of carry slices (1..WIDTH)
//  CHUNK   WIDTH/STAGES  localparam, bits summed per stage
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit accepts beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (ignored when in_sub=1)
//  in_sub     in   1      1: A - B (B inverted, carry-in forced 1); 0: A + B + in_cin
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of MSB (subtract: 1 = no borrow)
//  out_ovf    out  1      signed overflow; present only with PIPE_ADDER_OVF_EN
// BEHAVIOUR
//  - Reset (rst_n low, async): all stage valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0;
//    data regs cleared. in_ready is 1 immediately after reset (pipeline empty).
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - advance = ~out_valid | out_ready; in_ready = advance. All stage regs load only when advance=1
//    (global stall; bubbles are not squeezed). in_ready does not depend on in_valid.
//  - Stage k (0..STAGES-1) sums bits [k*CHUNK +: CHUNK] of A and B' (B' = in_sub ? ~B : B) with
//    carry from stage k-1 (stage 0: in_sub ? 1 : in_cin). Upper unprocessed operand slices and
//    lower finished sum slices travel in skew registers alongside; valid bit travels with them.
//  - Latency: exactly STAGES cycles from accepted input to out_valid with out_ready held 1.
//    Throughput: one result/cycle when unstalled.
//  - out_sum/out_cout/out_valid are registered; they hold stable while out_valid=1 & out_ready=0.
//  - Arithmetic mod 2^WIDTH; out_cout = bit WIDTH of A + B' + cin.
//  - Empty pipe with in_valid=0: stage valids shift 0s; out_valid falls after last result drains.
//  - Simultaneous accept and emit in one cycle is legal and required at full throughput.
//  - rst_n asserted mid-operation: all in-flight beats discarded, no partial result emitted.
//  - STAGES=1: single register stage, latency 1, identical handshake.
// CONFIGURATION
//  PIPE_ADDER_OVF_EN defined: out_ovf port exists; out_ovf = (A[MSB]==B'[MSB]) & (sum[MSB]!=A[MSB]),
//    sign bits carried down the pipe with the data, registered with out_sum, reset 0.
//  Not defined: out_ovf port and its pipeline bits absent; all other behaviour identical.
// STRUCTURE
//  - Shared package pipelined_adder_pkg: default WIDTH/STAGES constants, op-mode encoding
//    (OP_ADD=1'b0, OP_SUB=1'b1), function chunk_add(a,b,cin) returning {cout,sum} for CHUNK bits.
//  - One sub-module: adder_stage (one CHUNK slice + its valid/skew registers, enable=advance),
//    instantiated STAGES times via generate; top holds handshake logic and output regs.
// TESTING (WIDTH=16, STAGES=4, unless stated)
//  1 Reset: rst_n=0 with random inputs -> out_valid=0, out_sum=0, in_ready=1 after release.
//  2 Add: A=16'h00FF, B=16'h0001, cin=0, sub=0 -> after 4 clk out_sum=16'h0100, out_cout=0;
//    A=16'hFFFF, B=16'h0001 -> out_sum=16'h0000, out_cout=1 (carry across all slices).
//  3 Sub: A=16'h0005, B=16'h0007, sub=1 -> out_sum=16'hFFFE, out_cout=0; with OVF_EN,
//    A=16'h8000, B=16'h0001, sub=1 -> out_sum=16'h7FFF, out_ovf=1.
//  4 Back-pressure: stream 8 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0
//    while out_valid=1, no beat lost/duplicated, results in order, out_sum stable during stall.
//  5 Throughput: 100 random beats, in_valid and out_ready held 1 -> one result/cycle, all match model.
//  6 Mid-flight reset: assert rst_n low with 3 beats in pipe -> out_valid=0 at once, none emitted after.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and the slice-add helper for the pipelined add/subtract unit.
// Optional signed-overflow output is enabled by defining PIPE_ADDER_OVF_EN.
package pipelined_adder_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned STAGES_DEF = 4;
  // Widest carry slice the helper supports; slices are zero-extended to this.
  localparam int unsigned MAX_CHUNK  = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Returns {cout, sum}; with zero-extended operands the carry out of a
  // CHUNK-bit slice appears at bit CHUNK of the result.
  function automatic logic [MAX_CHUNK:0] chunk_add(
    input logic [MAX_CHUNK-1:0] a,
    input logic [MAX_CHUNK-1:0] b,
    input logic                 cin
  );
    chunk_add = {1'b0, a} + {1'b0, b} + {{MAX_CHUNK{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One carry slice of the pipelined adder: sums slice IDX and registers the
// operands, partial sum, carry and valid bit (plus overflow with PIPE_ADDER_OVF_EN).
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = WIDTH_DEF / STAGES_DEF,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_sum,
  input  logic             src_carry,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [MAX_CHUNK-1:0] a_ext_s;
  logic [MAX_CHUNK-1:0] b_ext_s;
  logic [MAX_CHUNK:0]   res_s;
  logic [WIDTH-1:0]     sum_nxt_s;

  // Slice sum merged into the partial result carried from earlier stages.
  always_comb begin
    a_ext_s = '0;
    b_ext_s = '0;
    a_ext_s[CHUNK-1:0] = src_a[IDX*CHUNK +: CHUNK];
    b_ext_s[CHUNK-1:0] = src_b[IDX*CHUNK +: CHUNK];
    res_s     = chunk_add(a_ext_s, b_ext_s, src_carry);
    sum_nxt_s = src_sum;
    sum_nxt_s[IDX*CHUNK +: CHUNK] = res_s[CHUNK-1:0];
  end

  // Stage registers; they all move together under the global advance enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (en) begin
      valid <= src_valid;
      a     <= src_a;
      b     <= src_b;
      sum   <= sum_nxt_s;
      carry <= res_s[CHUNK];
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // Only the last stage's value is meaningful: by then sum_nxt_s holds the final MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (en) begin
      ovf <= (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_nxt_s[WIDTH-1] != src_a[WIDTH-1]);
    end
  end
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit, one carry slice per stage, valid/ready handshake.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output out_ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  logic             advance_s;
  logic [STAGES:0]  valid_c;
  logic [STAGES:0]  carry_c;
  logic [WIDTH-1:0] a_c   [STAGES+1];
  logic [WIDTH-1:0] b_c   [STAGES+1];
  logic [WIDTH-1:0] sum_c [STAGES+1];
`ifdef PIPE_ADDER_OVF_EN
  logic [STAGES-1:0] ovf_c;
`endif

  // Global stall: nothing moves while a result waits on the consumer.
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s;

  // Subtraction is A + ~B + 1.
  assign valid_c[0] = in_valid;
  assign a_c[0]     = in_a;
  assign b_c[0]     = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign sum_c[0]   = '0;
  assign carry_c[0] = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance_s),
      .src_valid (valid_c[k]),
      .src_a     (a_c[k]),
      .src_b     (b_c[k]),
      .src_sum   (sum_c[k]),
      .src_carry (carry_c[k]),
      .valid     (valid_c[k+1]),
      .a         (a_c[k+1]),
      .b         (b_c[k+1]),
      .sum       (sum_c[k+1]),
      .carry     (carry_c[k+1])
`ifdef PIPE_ADDER_OVF_EN
      ,
      .ovf       (ovf_c[k])
`endif
    );
  end

  // The last stage's registers are the output registers.
  assign out_valid = valid_c[STAGES];
  assign out_sum   = sum_c[STAGES];
  assign out_cout  = carry_c[STAGES];
`ifdef PIPE_ADDER_OVF_EN
  assign out_ovf   = ovf_c[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4) with a queue scoreboard.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef PIPE_ADDER_OVF_EN
  logic         out_ovf;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [W+1:0] sb [$];   // {ovf, cout, sum}

  // Directed table: a, b, cin, sub and the hand-computed results.
  logic [W-1:0] dir_a    [7] = '{16'h00FF, 16'hFFFF, 16'h1234, 16'h0005, 16'h8000, 16'h0007, 16'h7FFF};
  logic [W-1:0] dir_b    [7] = '{16'h0001, 16'h0001, 16'h4321, 16'h0007, 16'h0001, 16'h0005, 16'h0001};
  logic         dir_cin  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic         dir_sub  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [W-1:0] dir_sum  [7] = '{16'h0100, 16'h0000, 16'h5556, 16'hFFFE, 16'h7FFF, 16'h0002, 16'h8000};
  logic         dir_cout [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic         dir_ovf  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {ovf, r};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom);
      in_sub    = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      vectors++;
      if ({out_valid, out_cout, out_sum} !== {1'b0, 1'b0, 16'h0000}) begin
        miscompares++;
        $display("FAIL reset_outputs: got valid=%b cout=%b sum=%h, expected 0/0/0000",
                 out_valid, out_cout, out_sum);
      end
`ifdef PIPE_ADDER_OVF_EN
      vectors++;
      if (out_ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ovf: got %b expected 0", out_ovf);
      end
`endif
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add_sub;
    logic [W+1:0] e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_a = dir_a[i]; in_b = dir_b[i]; in_cin = dir_cin[i]; in_sub = dir_sub[i];
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL addsub_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      sb.push_back({dir_ovf[i], dir_cout[i], dir_sum[i]});
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
        tick();
        lat++;
      end
      vectors++;
      if (lat != S) begin
        miscompares++;
        $display("FAIL addsub_latency[%0d]: got %0d cycles expected %0d", i, lat, S);
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      vectors++;
      if ({out_valid, out_cout, out_sum} !== {1'b1, e[W:0]}) begin
        miscompares++;
        $display("FAIL addsub_result[%0d]: got valid=%b cout=%b sum=%h expected 1/%b/%h",
                 i, out_valid, out_cout, out_sum, e[W], e[W-1:0]);
      end
`ifdef PIPE_ADDER_OVF_EN
      vectors++;
      if (out_ovf !== e[W+1]) begin
        miscompares++;
        $display("FAIL addsub_ovf[%0d]: got %b expected %b", i, out_ovf, e[W+1]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_back_pressure;
    logic [W-1:0] ba [8];
    logic [W-1:0] bbv [8];
    logic [W+1:0] e;
    logic [W:0]   held;
    logic         held_valid;
    int sent, got, stalled;
    for (int i = 0; i < 8; i++) begin
      ba[i]  = W'($urandom);
      bbv[i] = W'($urandom);
    end
    sent = 0; got = 0; stalled = 0; held_valid = 1'b0; held = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      out_ready = !(c >= 6 && c < 11);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = ba[sent]; in_b = bbv[sent]; in_sub = sent[0]; in_cin = sent[1];
      end else begin
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
      end
      #1;
      vectors++;
      if (in_ready !== (!out_valid || out_ready)) begin
        miscompares++;
        $display("FAIL bp_in_ready c=%0d: got %b expected %b", c, in_ready, (!out_valid || out_ready));
      end
      if (out_valid && !out_ready) stalled++;
      if (held_valid) begin
        vectors++;
        if ({out_valid, out_cout, out_sum} !== {1'b1, held}) begin
          miscompares++;
          $display("FAIL bp_stable c=%0d: got valid=%b %h expected 1 %h",
                   c, out_valid, {out_cout, out_sum}, held);
        end
      end
      held_valid = out_valid && !out_ready;
      held = {out_cout, out_sum};
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL bp_spurious c=%0d: got sum=%h expected no output", c, out_sum);
        end else begin
          e = sb.pop_front();
          if ({out_cout, out_sum} !== e[W:0]) begin
            miscompares++;
            $display("FAIL bp_result[%0d]: got %h expected %h", got, {out_cout, out_sum}, e[W:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 8 || sent != 8 || sb.size() != 0 || stalled != 5) begin
      miscompares++;
      $display("FAIL bp_count: got sent=%0d recv=%0d left=%0d stalled=%0d expected 8/8/0/5",
               sent, got, sb.size(), stalled);
    end
  endtask

  task automatic test_throughput;
    logic [W+1:0] e;
    int sent, got, last_c, drops;
    sent = 0; got = 0; last_c = -1; drops = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && got < 100; c++) begin
      in_valid = (sent < 100);
      in_a = W'($urandom); in_b = W'($urandom);
      in_cin = 1'($urandom); in_sub = 1'($urandom);
      #1;
      if (in_ready !== 1'b1) drops++;
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL tp_spurious c=%0d: got sum=%h expected no output", c, out_sum);
        end else begin
          e = sb.pop_front();
          if ({out_cout, out_sum} !== e[W:0]) begin
            miscompares++;
            $display("FAIL tp_result[%0d]: got %h expected %h", got, {out_cout, out_sum}, e[W:0]);
          end
        end
        got++;
        last_c = c;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 100 || last_c != 100 + S - 1 || drops != 0) begin
      miscompares++;
      $display("FAIL tp_rate: got recv=%0d last_cycle=%0d ready_drops=%0d expected 100/%0d/0",
               got, last_c, drops, 100 + S - 1);
    end
  endtask

  task automatic test_midflight_reset;
    int leaks;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'b0; in_sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mr_prefill: got out_valid=%b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_cout, out_sum} !== {1'b0, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL mr_async_clear: got valid=%b cout=%b sum=%h expected 0/0/0000",
               out_valid, out_cout, out_sum);
    end
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    leaks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b0) leaks++;
    end
    vectors++;
    if (leaks != 0) begin
      miscompares++;
      $display("FAIL mr_no_emit: got %0d valid cycles after reset expected 0", leaks);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_pressure();
    test_throughput();
    test_midflight_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
